encap_ekey_lookup: RTL and testbench

//  Exact-match lookup engine that issues reads into the encap ekey memories.
//  Per request it hashes the key, reads both ekey hash tables and compares the bucket keys.
//  On a hit it fetches the ekey value and returns {hit, err, value} on a valid/ready port.

---
 rtl/encap_ekey_lookup_pkg.sv | 44 ++++
 rtl/encap_ekey_lookup_if.sv | 57 +++++
 rtl/encap_ekey_lookup_hash.sv | 32 +++
 rtl/encap_ekey_lookup.sv | 195 +++++++++++++++++++
 tb/tb_encap_ekey_lookup.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encap_ekey_lookup_pkg.sv
// Shared types, sizes and FSM encoding for the encap ekey exact-match lookup engine.
// Bucket layout MSB..LSB is {valid, key, vptr}; the packed struct below fixes the field offsets.
package encap_ekey_lookup_pkg;

    localparam int KEY_NBITS         = 16;
    localparam int DEPTH_NBITS       = 6;
    localparam int VALUE_DEPTH_NBITS = 4;
    localparam int VALUE_NBITS       = 32;
    localparam int BUCKET_NBITS      = 1 + KEY_NBITS + VALUE_DEPTH_NBITS;
    localparam int TIMEOUT_CYC       = 256;
    localparam int TIMER_NBITS       = $clog2(TIMEOUT_CYC);
    localparam int CNT_NBITS         = 32;

    typedef logic [KEY_NBITS-1:0]         key_t;
    typedef logic [DEPTH_NBITS-1:0]       hidx_t;
    typedef logic [VALUE_DEPTH_NBITS-1:0] vptr_t;
    typedef logic [VALUE_NBITS-1:0]       value_t;
    typedef logic [TIMER_NBITS-1:0]       timer_t;
    typedef logic [CNT_NBITS-1:0]         cnt_t;

    typedef struct packed {
        logic  valid;
        key_t  key;
        vptr_t vptr;
    } bucket_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HT_RD    = 3'd1,
        ST_HT_WAIT  = 3'd2,
        ST_VAL_RD   = 3'd3,
        ST_VAL_WAIT = 3'd4,
        ST_RESP     = 3'd5
    } state_e;

    function automatic logic bucket_match(input bucket_t b, input key_t k);
        return b.valid && (b.key == k);
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/encap_ekey_lookup_if.sv
// Request/result handshake plus the two hash-table and value-memory read ports of the lookup engine.
// master = the lookup engine, slave = pipeline and memory side.
interface encap_ekey_lookup_if
    import encap_ekey_lookup_pkg::*;
;
    logic    lu_req;
    key_t    lu_key;
    logic    lu_ready;

    logic    ekey_hash_table0_rd;
    hidx_t   ekey_hash_table0_raddr;
    logic    ekey_hash_table0_ack;
    bucket_t ekey_hash_table0_rdata;

    logic    ekey_hash_table1_rd;
    hidx_t   ekey_hash_table1_raddr;
    logic    ekey_hash_table1_ack;
    bucket_t ekey_hash_table1_rdata;

    logic    ekey_value_rd;
    vptr_t   ekey_value_raddr;
    logic    ekey_value_ack;
    value_t  ekey_value_rdata;

    logic    res_valid;
    logic    res_ready;
    logic    res_hit;
    logic    res_err;
    value_t  res_value;

    modport master (
        input  lu_req, lu_key,
        output lu_ready,
        output ekey_hash_table0_rd, ekey_hash_table0_raddr,
        input  ekey_hash_table0_ack, ekey_hash_table0_rdata,
        output ekey_hash_table1_rd, ekey_hash_table1_raddr,
        input  ekey_hash_table1_ack, ekey_hash_table1_rdata,
        output ekey_value_rd, ekey_value_raddr,
        input  ekey_value_ack, ekey_value_rdata,
        output res_valid, res_hit, res_err, res_value,
        input  res_ready
    );

    modport slave (
        output lu_req, lu_key,
        input  lu_ready,
        input  ekey_hash_table0_rd, ekey_hash_table0_raddr,
        output ekey_hash_table0_ack, ekey_hash_table0_rdata,
        input  ekey_hash_table1_rd, ekey_hash_table1_raddr,
        output ekey_hash_table1_ack, ekey_hash_table1_rdata,
        input  ekey_value_rd, ekey_value_raddr,
        output ekey_value_ack, ekey_value_rdata,
        input  res_valid, res_hit, res_err, res_value,
        output res_ready
    );

endinterface

// File: rtl/encap_ekey_lookup_hash.sv
// Combinational key -> {h0, h1}: XOR-fold of the key (h0) and of the bit-reversed key (h1).
// Zero latency; the last fold chunk is zero-padded at the top.
module encap_ekey_hash
    import encap_ekey_lookup_pkg::*;
(
    input  key_t  key_i,
    output hidx_t h0_o,
    output hidx_t h1_o
);

    localparam int NCHUNK    = (KEY_NBITS + DEPTH_NBITS - 1) / DEPTH_NBITS;
    localparam int PAD_NBITS = NCHUNK * DEPTH_NBITS;

    key_t                 key_rev;
    logic [PAD_NBITS-1:0] pad0;
    logic [PAD_NBITS-1:0] pad1;

    always_comb begin
        for (int i = 0; i < KEY_NBITS; i++) begin
            key_rev[i] = key_i[KEY_NBITS-1-i];
        end
        pad0 = PAD_NBITS'(key_i);
        pad1 = PAD_NBITS'(key_rev);
        h0_o = '0;
        h1_o = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            h0_o = h0_o ^ pad0[c*DEPTH_NBITS +: DEPTH_NBITS];
            h1_o = h1_o ^ pad1[c*DEPTH_NBITS +: DEPTH_NBITS];
        end
    end

endmodule

// File: rtl/encap_ekey_lookup.sv
// Exact-match lookup: hash key, read both ekey tables, compare buckets, fetch value on hit.
// One lookup outstanding; result held on res_valid until res_ready, any ack wait bounded by TIMEOUT_CYC.
module encap_ekey_lookup
    import encap_ekey_lookup_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    encap_ekey_lookup_if.master  bus,
    output cnt_t                 hit_cnt_o,
    output cnt_t                 miss_cnt_o
);

    state_e  state_q, state_d;
    key_t    key_q, key_d;
    hidx_t   h0_q, h0_d;
    hidx_t   h1_q, h1_d;
    bucket_t b0_q, b0_d;
    bucket_t b1_q, b1_d;
    logic    f0_q, f0_d;
    logic    f1_q, f1_d;
    vptr_t   vptr_q, vptr_d;
    timer_t  timer_q, timer_d;
    logic    res_hit_q, res_hit_d;
    logic    res_err_q, res_err_d;
    value_t  res_value_q, res_value_d;
    cnt_t    hit_cnt_q, hit_cnt_d;
    cnt_t    miss_cnt_q, miss_cnt_d;

    hidx_t   h0;
    hidx_t   h1;
    bucket_t b0_eff;
    bucket_t b1_eff;
    logic    f0_eff;
    logic    f1_eff;
    logic    hit0;
    logic    hit1;
    logic    timer_done;

    encap_ekey_hash u_hash (
        .key_i (bus.lu_key),
        .h0_o  (h0),
        .h1_o  (h1)
    );

    // An ack in the deciding cycle is folded in directly so a same-cycle pair decides immediately.
    assign b0_eff     = bus.ekey_hash_table0_ack ? bus.ekey_hash_table0_rdata : b0_q;
    assign b1_eff     = bus.ekey_hash_table1_ack ? bus.ekey_hash_table1_rdata : b1_q;
    assign f0_eff     = f0_q | bus.ekey_hash_table0_ack;
    assign f1_eff     = f1_q | bus.ekey_hash_table1_ack;
    assign hit0       = bucket_match(b0_eff, key_q);
    assign hit1       = bucket_match(b1_eff, key_q);
    assign timer_done = (timer_q == timer_t'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        h0_d        = h0_q;
        h1_d        = h1_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        f0_d        = f0_q;
        f1_d        = f1_q;
        vptr_d      = vptr_q;
        timer_d     = timer_q;
        res_hit_d   = res_hit_q;
        res_err_d   = res_err_q;
        res_value_d = res_value_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.lu_req) begin
                    key_d   = bus.lu_key;
                    h0_d    = h0;
                    h1_d    = h1;
                    state_d = ST_HT_RD;
                end
            end
            ST_HT_RD: begin
                timer_d = '0;
                f0_d    = 1'b0;
                f1_d    = 1'b0;
                state_d = ST_HT_WAIT;
            end
            ST_HT_WAIT: begin
                b0_d = b0_eff;
                b1_d = b1_eff;
                f0_d = f0_eff;
                f1_d = f1_eff;
                if (f0_eff && f1_eff) begin
                    if (hit0) begin
                        vptr_d  = b0_eff.vptr;
                        state_d = ST_VAL_RD;
                    end else if (hit1) begin
                        vptr_d  = b1_eff.vptr;
                        state_d = ST_VAL_RD;
                    end else begin
                        res_hit_d   = 1'b0;
                        res_err_d   = 1'b0;
                        res_value_d = '0;
                        miss_cnt_d  = sat_inc(miss_cnt_q);
                        state_d     = ST_RESP;
                    end
                end else if (timer_done) begin
                    res_hit_d   = 1'b0;
                    res_err_d   = 1'b1;
                    res_value_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_VAL_RD: begin
                timer_d = '0;
                state_d = ST_VAL_WAIT;
            end
            ST_VAL_WAIT: begin
                if (bus.ekey_value_ack) begin
                    res_hit_d   = 1'b1;
                    res_err_d   = 1'b0;
                    res_value_d = bus.ekey_value_rdata;
                    hit_cnt_d   = sat_inc(hit_cnt_q);
                    state_d     = ST_RESP;
                end else if (timer_done) begin
                    res_hit_d   = 1'b0;
                    res_err_d   = 1'b1;
                    res_value_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            h0_q        <= '0;
            h1_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            f0_q        <= 1'b0;
            f1_q        <= 1'b0;
            vptr_q      <= '0;
            timer_q     <= '0;
            res_hit_q   <= 1'b0;
            res_err_q   <= 1'b0;
            res_value_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            f0_q        <= f0_d;
            f1_q        <= f1_d;
            vptr_q      <= vptr_d;
            timer_q     <= timer_d;
            res_hit_q   <= res_hit_d;
            res_err_q   <= res_err_d;
            res_value_q <= res_value_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.lu_ready               = (state_q == ST_IDLE);
    assign bus.ekey_hash_table0_rd    = (state_q == ST_HT_RD);
    assign bus.ekey_hash_table0_raddr = h0_q;
    assign bus.ekey_hash_table1_rd    = (state_q == ST_HT_RD);
    assign bus.ekey_hash_table1_raddr = h1_q;
    assign bus.ekey_value_rd          = (state_q == ST_VAL_RD);
    assign bus.ekey_value_raddr       = vptr_q;
    assign bus.res_valid              = (state_q == ST_RESP);
    assign bus.res_hit                = res_hit_q;
    assign bus.res_err                = res_err_q;
    assign bus.res_value              = res_value_q;
    assign hit_cnt_o                  = hit_cnt_q;
    assign miss_cnt_o                 = miss_cnt_q;

endmodule

// File: tb/tb_encap_ekey_lookup.sv
// Directed bench for encap_ekey_lookup: memory responders with per-port ack delay, result scoreboard.
module tb_encap_ekey_lookup;
    import encap_ekey_lookup_pkg::*;

    typedef struct {
        logic   hit;
        logic   err;
        value_t value;
    } exp_t;

    logic clk;
    logic rst_n;
    cnt_t hit_cnt;
    cnt_t miss_cnt;

    encap_ekey_lookup_if bus ();

    encap_ekey_lookup dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bucket_t t0 [0:(1<<DEPTH_NBITS)-1];
    bucket_t t1 [0:(1<<DEPTH_NBITS)-1];
    value_t  vmem [0:(1<<VALUE_DEPTH_NBITS)-1];
    int      d0 = 1, d1 = 1, dv = 1;
    int      rd0_cnt = 0, rd1_cnt = 0, rdv_cnt = 0, vack_cnt = 0;
    hidx_t   last_ra0, last_ra1;
    vptr_t   last_rav;
    exp_t    sb [$];
    int      vectors = 0;
    int      miscompares = 0;
    int      exp_hit = 0, exp_miss = 0;

    function automatic hidx_t h0m(input key_t k);
        hidx_t h = '0;
        for (int i = 0; i < KEY_NBITS; i++) h[i % DEPTH_NBITS] ^= k[i];
        return h;
    endfunction

    function automatic hidx_t h1m(input key_t k);
        hidx_t h = '0;
        for (int i = 0; i < KEY_NBITS; i++) h[i % DEPTH_NBITS] ^= k[KEY_NBITS-1-i];
        return h;
    endfunction

    always @(negedge clk) begin
        if (bus.ekey_hash_table0_rd) begin rd0_cnt++; last_ra0 = bus.ekey_hash_table0_raddr; end
        if (bus.ekey_hash_table1_rd) begin rd1_cnt++; last_ra1 = bus.ekey_hash_table1_raddr; end
        if (bus.ekey_value_rd)       begin rdv_cnt++; last_rav = bus.ekey_value_raddr; end
    end

    initial begin
        hidx_t a;
        bus.ekey_hash_table0_ack = 1'b0;
        bus.ekey_hash_table0_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.ekey_hash_table0_rd) begin
                a = bus.ekey_hash_table0_raddr;
                repeat (d0) @(negedge clk);
                bus.ekey_hash_table0_ack = 1'b1;
                bus.ekey_hash_table0_rdata = t0[a];
                @(negedge clk);
                bus.ekey_hash_table0_ack = 1'b0;
            end
        end
    end

    initial begin
        hidx_t a;
        bus.ekey_hash_table1_ack = 1'b0;
        bus.ekey_hash_table1_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.ekey_hash_table1_rd) begin
                a = bus.ekey_hash_table1_raddr;
                repeat (d1) @(negedge clk);
                bus.ekey_hash_table1_ack = 1'b1;
                bus.ekey_hash_table1_rdata = t1[a];
                @(negedge clk);
                bus.ekey_hash_table1_ack = 1'b0;
            end
        end
    end

    initial begin
        vptr_t a;
        bus.ekey_value_ack = 1'b0;
        bus.ekey_value_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.ekey_value_rd) begin
                a = bus.ekey_value_raddr;
                repeat (dv) @(negedge clk);
                bus.ekey_value_ack = 1'b1;
                bus.ekey_value_rdata = vmem[a];
                @(negedge clk);
                bus.ekey_value_ack = 1'b0;
                vack_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input key_t k, input logic eh, input logic ee, input value_t ev);
        int n = 0;
        exp_t e;
        while (!bus.lu_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_lu_ready_idle"}, 64'(bus.lu_ready), 64'd1);
        bus.lu_req = 1'b1;
        bus.lu_key = k;
        @(negedge clk);
        bus.lu_req = 1'b0;
        chk({tag, "_lu_ready_busy"}, 64'(bus.lu_ready), 64'd0);
        e.hit = eh; e.err = ee; e.value = ev;
        sb.push_back(e);
    endtask

    task automatic get_result(input string tag, input int hold);
        int   n = 0;
        exp_t e;
        logic h, er;
        value_t v;
        while (!bus.res_valid && n < 600) begin @(negedge clk); n++; end
        chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
        e = sb.pop_front();
        h = bus.res_hit; er = bus.res_err; v = bus.res_value;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_fields"}, {29'd0, bus.res_valid, bus.res_hit, bus.res_err, bus.res_value},
                {29'd0, 1'b1, h, er, v});
            chk({tag, "_hold_lu_ready"}, 64'(bus.lu_ready), 64'd0);
        end
        chk({tag, "_hit"},   64'(bus.res_hit),   64'(e.hit));
        chk({tag, "_err"},   64'(bus.res_err),   64'(e.err));
        chk({tag, "_value"}, 64'(bus.res_value), 64'(e.value));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int b0, b1, bv, base, n;
        key_t k1, k2, k3, k4, k5, k6, k7;
        k1 = 16'hA5C3; k2 = 16'h1234; k3 = 16'hBEEF; k4 = 16'h0F0F;
        k5 = 16'h7E81; k6 = 16'h5A5A; k7 = 16'hC001;
        for (int i = 0; i < (1<<DEPTH_NBITS); i++) begin t0[i] = '0; t1[i] = '0; end
        for (int i = 0; i < (1<<VALUE_DEPTH_NBITS); i++) vmem[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
        bus.lu_req = 1'b0; bus.lu_key = '0; bus.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_lu_ready",  64'(bus.lu_ready), 64'd1);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_rd_pulses", {61'd0, bus.ekey_hash_table0_rd, bus.ekey_hash_table1_rd, bus.ekey_value_rd}, 64'd0);
        chk("rst_res_fields", {31'd0, bus.res_hit, bus.res_err, bus.res_value}, 64'd0);
        chk("rst_counters", {hit_cnt, miss_cnt}, 64'd0);

        // table0-only hit
        t0[h0m(k1)] = '{valid: 1'b1, key: k1, vptr: vptr_t'(5)};
        b0 = rd0_cnt; b1 = rd1_cnt; bv = rdv_cnt;
        issue("t0hit", k1, 1'b1, 1'b0, vmem[5]);
        get_result("t0hit", 0);
        exp_hit++;
        chk("t0hit_rd0_once", 64'(rd0_cnt - b0), 64'd1);
        chk("t0hit_rd1_once", 64'(rd1_cnt - b1), 64'd1);
        chk("t0hit_rdv_once", 64'(rdv_cnt - bv), 64'd1);
        chk("t0hit_raddr0", 64'(last_ra0), 64'(h0m(k1)));
        chk("t0hit_raddr1", 64'(last_ra1), 64'(h1m(k1)));
        chk("t0hit_vaddr", 64'(last_rav), 64'd5);
        chk("t0hit_hit_cnt", 64'(hit_cnt), 64'(exp_hit));

        // both tables hit, table0 has priority
        t0[h0m(k2)] = '{valid: 1'b1, key: k2, vptr: vptr_t'(3)};
        t1[h1m(k2)] = '{valid: 1'b1, key: k2, vptr: vptr_t'(9)};
        issue("both", k2, 1'b1, 1'b0, vmem[3]);
        get_result("both", 0);
        exp_hit++;
        chk("both_vaddr", 64'(last_rav), 64'd3);

        // absent key
        bv = rdv_cnt;
        issue("absent", k3, 1'b0, 1'b0, '0);
        get_result("absent", 0);
        exp_miss++;
        chk("absent_no_vrd", 64'(rdv_cnt - bv), 64'd0);
        chk("absent_miss_cnt", 64'(miss_cnt), 64'(exp_miss));

        // matching key but bucket invalid
        t0[h0m(k4)] = '{valid: 1'b0, key: k4, vptr: vptr_t'(7)};
        t1[h1m(k4)] = '{valid: 1'b0, key: k4, vptr: vptr_t'(8)};
        bv = rdv_cnt;
        issue("invalid", k4, 1'b0, 1'b0, '0);
        get_result("invalid", 0);
        exp_miss++;
        chk("invalid_no_vrd", 64'(rdv_cnt - bv), 64'd0);
        chk("invalid_miss_cnt", 64'(miss_cnt), 64'(exp_miss));

        // table1 acks 10 cycles before table0; table0 still wins
        d0 = 12; d1 = 2;
        t0[h0m(k5)] = '{valid: 1'b1, key: k5, vptr: vptr_t'(2)};
        t1[h1m(k5)] = '{valid: 1'b1, key: k5, vptr: vptr_t'(11)};
        issue("late_t0", k5, 1'b1, 1'b0, vmem[2]);
        get_result("late_t0", 0);
        exp_hit++;
        chk("late_t0_vaddr", 64'(last_rav), 64'd2);

        // table1-only hit with skewed acks
        t0[h0m(k7)] = '{valid: 1'b1, key: k7 ^ 16'h0001, vptr: vptr_t'(1)};
        t1[h1m(k7)] = '{valid: 1'b1, key: k7, vptr: vptr_t'(11)};
        issue("t1hit", k7, 1'b1, 1'b0, vmem[11]);
        get_result("t1hit", 0);
        exp_hit++;
        chk("t1hit_vaddr", 64'(last_rav), 64'd11);
        d0 = 1; d1 = 1;

        // value ack withheld past the timeout, then arrives while idle
        dv = 300;
        t0[h0m(k6)] = '{valid: 1'b1, key: k6, vptr: vptr_t'(4)};
        base = vack_cnt;
        issue("timeout", k6, 1'b0, 1'b1, '0);
        get_result("timeout", 0);
        chk("timeout_hit_cnt", 64'(hit_cnt), 64'(exp_hit));
        chk("timeout_miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        n = 0;
        while (vack_cnt == base && n < 200) begin @(negedge clk); n++; end
        chk("late_ack_delivered", 64'(vack_cnt != base), 64'd1);
        @(negedge clk);
        chk("late_ack_lu_ready", 64'(bus.lu_ready), 64'd1);
        chk("late_ack_no_result", 64'(bus.res_valid), 64'd0);
        dv = 1;
        t0[h0m(k1)] = '{valid: 1'b1, key: k1, vptr: vptr_t'(5)};
        issue("after_to", k1, 1'b1, 1'b0, vmem[5]);
        get_result("after_to", 0);
        exp_hit++;
        chk("after_to_hit_cnt", 64'(hit_cnt), 64'(exp_hit));

        // consumer stalls for 5 cycles
        t0[h0m(k2)] = '{valid: 1'b1, key: k2, vptr: vptr_t'(3)};
        issue("stall", k2, 1'b1, 1'b0, vmem[3]);
        get_result("stall", 5);
        exp_hit++;
        chk("stall_hit_cnt", 64'(hit_cnt), 64'(exp_hit));

        // reset while waiting on the tables
        d0 = 20; d1 = 20;
        issue("rst_mid", k1, 1'b1, 1'b0, vmem[5]);
        void'(sb.pop_front());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_hit = 0; exp_miss = 0;
        chk("rst_mid_lu_ready", 64'(bus.lu_ready), 64'd1);
        chk("rst_mid_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_mid_counters", {hit_cnt, miss_cnt}, {32'(exp_hit), 32'(exp_miss)});
        b0 = rd0_cnt; bv = rdv_cnt;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_result", 64'(bus.res_valid), 64'd0);
        chk("rst_mid_no_rd", 64'({rd0_cnt - b0, rdv_cnt - bv}), 64'd0);
        chk("rst_mid_still_idle", 64'(bus.lu_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
